// File: rtl/id_ex_stage_reg_if.sv
// ID/EX payload bundle: decoded instruction fields from ID and their registered EX copy.
// master drives the ID side and observes EX; slave is the pipeline register itself.
interface id_ex_stage_reg_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_uses_rt;
  logic [DW-1:0] read_data_1, read_data_2, id_imm;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]    id_alu_op;

  logic          ex_valid;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_data_1, ex_data_2, ex_imm;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]    ex_alu_op;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, read_data_1, read_data_2, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_data_1, ex_data_2, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, read_data_1, read_data_2, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst, id_alu_op,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_data_1, ex_data_2, ex_imm,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with WB write-through bypass, load-use bubble insertion,
// flush/hold control and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_reg_if.slave bus,
  input  logic             wb_reg_write,
  input  logic [AW-1:0]    wb_write_reg,
  input  logic [DW-1:0]    wb_write_data,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] bubble_count
);

  logic          ex_valid_q;
  logic [AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic [DW-1:0] ex_data_1_q, ex_data_2_q, ex_imm_q;
  logic          ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
  logic          ex_mem_to_reg_q, ex_alu_src_q, ex_reg_dst_q;
  logic [3:0]    ex_alu_op_q;

  logic [DW-1:0] op1, op2;
  logic          load_use, bubble, load;

  // RegFile writes on the edge, so a same-cycle writeback must be forwarded; r0 never is.
  always_comb begin
    op1 = bus.read_data_1;
    op2 = bus.read_data_2;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == bus.id_rs))
      op1 = wb_write_data;
    if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == bus.id_rt))
      op2 = wb_write_data;
  end

  assign load_use = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rt_q != '0) &
                    ((ex_rt_q == bus.id_rs) | (bus.id_uses_rt & (ex_rt_q == bus.id_rt)));
  assign stall_if_id = load_use | ex_hold;

  // Flush beats hold; a load-use bubble only applies when EX is free to advance.
  assign bubble = flush | (~ex_hold & load_use);
  assign load   = ~flush & ~ex_hold & ~load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_data_1_q <= '0;
      ex_data_2_q <= '0;
      ex_imm_q    <= '0;
      ex_alu_op_q <= '0;
    end else if (load) begin
      ex_rs_q     <= bus.id_rs;
      ex_rt_q     <= bus.id_rt;
      ex_rd_q     <= bus.id_rd;
      ex_data_1_q <= op1;
      ex_data_2_q <= op2;
      ex_imm_q    <= bus.id_imm;
      ex_alu_op_q <= bus.id_alu_op;
    end
  end

  // Controls are gated by id_valid so no write-side control is ever live without a valid op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_dst_q    <= 1'b0;
    end else if (bubble) begin
      ex_valid_q      <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_reg_dst_q    <= 1'b0;
    end else if (load) begin
      ex_valid_q      <= bus.id_valid;
      ex_reg_write_q  <= bus.id_valid & bus.id_reg_write;
      ex_mem_read_q   <= bus.id_valid & bus.id_mem_read;
      ex_mem_write_q  <= bus.id_valid & bus.id_mem_write;
      ex_mem_to_reg_q <= bus.id_valid & bus.id_mem_to_reg;
      ex_alu_src_q    <= bus.id_valid & bus.id_alu_src;
      ex_reg_dst_q    <= bus.id_valid & bus.id_reg_dst;
    end
  end

  // Only bubbles that displace a real instruction are counted; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_count <= '0;
    else if (bubble && bus.id_valid && (bubble_count != '1))
      bubble_count <= bubble_count + 1'b1;
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rs         = ex_rs_q;
  assign bus.ex_rt         = ex_rt_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_data_1     = ex_data_1_q;
  assign bus.ex_data_2     = ex_data_2_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_reg_write  = ex_reg_write_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_mem_write  = ex_mem_write_q;
  assign bus.ex_mem_to_reg = ex_mem_to_reg_q;
  assign bus.ex_alu_src    = ex_alu_src_q;
  assign bus.ex_reg_dst    = ex_reg_dst_q;
  assign bus.ex_alu_op     = ex_alu_op_q;

endmodule
